// File: rtl/disp_out_mux.sv
// disp_out_mux: time-multiplexed seven-segment display driver.
// Scans NUM_DIGITS digits, one REFRESH_DIV-cycle slot each. The first
// GHOST_CYCLES cycles of every slot are dead time with the anode off.
// Inputs are captured once per frame so a frame never mixes old and new data.
// Ports:
//   clk, rst_n   - clock (rising edge) and async active-low reset
//   enable_i     - 0 blanks all pins; the scan itself keeps running
//   data_i       - packed hex nibbles, digit i at [4i+3:4i], digit 0 rightmost
//   dp_i         - per-digit decimal point, 1 = lit
//   blank_i      - per-digit blank, 1 = anode never asserted
//   seg_o        - segments {g,f,e,d,c,b,a}
//   dp_o         - decimal-point segment
//   anode_o      - one-hot digit select when asserted
// Every output pin is asserted low when ACTIVE_LOW=1, high when 0.
module disp_out_mux #(
    parameter int unsigned NUM_DIGITS   = 4,
    parameter int unsigned REFRESH_DIV  = 100000,
    parameter int unsigned GHOST_CYCLES = 1000,
    parameter bit          ACTIVE_LOW   = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      enable_i,
    input  logic [4*NUM_DIGITS-1:0]   data_i,
    input  logic [NUM_DIGITS-1:0]     dp_i,
    input  logic [NUM_DIGITS-1:0]     blank_i,
    output logic [6:0]                seg_o,
    output logic                      dp_o,
    output logic [NUM_DIGITS-1:0]     anode_o
);

    localparam int unsigned PRE_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [PRE_W-1:0] PRE_LAST  = PRE_W'(REFRESH_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] GHOST_END = PRE_W'(GHOST_CYCLES);

    logic [PRE_W-1:0]          pre_cnt_q,    pre_cnt_d;
    logic [IDX_W-1:0]          digit_idx_q,  digit_idx_d;
    logic [4*NUM_DIGITS-1:0]   snap_data_q,  snap_data_d;
    logic [NUM_DIGITS-1:0]     snap_dp_q,    snap_dp_d;
    logic [NUM_DIGITS-1:0]     snap_blank_q, snap_blank_d;
    logic                      load_pending_q;
    logic [NUM_DIGITS-1:0]     anode_q,      anode_d;
    logic [6:0]                seg_q,        seg_d;
    logic                      dp_q,         dp_d;

    logic                      pre_wrap;
    logic                      snap_load;
    logic                      active;
    logic [3:0]                cur_nib;
    logic                      cur_dp;
    logic                      cur_blank;

    // Hex nibble to active-high gfedcba pattern.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            default: s = 7'h71;
        endcase
        return s;
    endfunction

    // Prescaler, digit index, snapshot and next output values.
    always_comb begin
        pre_cnt_d    = pre_cnt_q;
        digit_idx_d  = digit_idx_q;
        snap_data_d  = snap_data_q;
        snap_dp_d    = snap_dp_q;
        snap_blank_d = snap_blank_q;
        anode_d      = '0;
        seg_d        = '0;
        dp_d         = 1'b0;
        cur_nib      = '0;
        cur_dp       = 1'b0;
        cur_blank    = 1'b0;

        pre_wrap = (pre_cnt_q == PRE_LAST);
        // Frame boundary coincides with the digit index wrapping to 0, so
        // digit 0 of every frame already shows the freshly captured inputs.
        snap_load = load_pending_q || (pre_wrap && (digit_idx_q == IDX_LAST));

        if (pre_wrap) begin
            pre_cnt_d   = '0;
            digit_idx_d = (digit_idx_q == IDX_LAST) ? '0 : digit_idx_q + IDX_W'(1);
        end else begin
            pre_cnt_d = pre_cnt_q + PRE_W'(1);
        end

        if (snap_load) begin
            snap_data_d  = data_i;
            snap_dp_d    = dp_i;
            snap_blank_d = blank_i;
        end

        // Select the current digit without a variable index, so that a
        // digit count that is not a power of two never reads out of range.
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_idx_q == IDX_W'(k)) begin
                cur_nib   = snap_data_q[4*k +: 4];
                cur_dp    = snap_dp_q[k];
                cur_blank = snap_blank_q[k];
            end
        end

        active = enable_i && !cur_blank && (pre_cnt_q >= GHOST_END);

        for (int k = 0; k < NUM_DIGITS; k++) begin
            anode_d[k] = active && (digit_idx_q == IDX_W'(k));
        end
        seg_d = active ? hex_to_seg(cur_nib) : 7'h00;
        dp_d  = active && cur_dp;
    end

    // State and output registers; outputs hold the active-high view.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt_q      <= '0;
            digit_idx_q    <= '0;
            snap_data_q    <= '0;
            snap_dp_q      <= '0;
            snap_blank_q   <= '0;
            load_pending_q <= 1'b1;
            anode_q        <= '0;
            seg_q          <= '0;
            dp_q           <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            digit_idx_q    <= digit_idx_d;
            snap_data_q    <= snap_data_d;
            snap_dp_q      <= snap_dp_d;
            snap_blank_q   <= snap_blank_d;
            load_pending_q <= 1'b0;
            anode_q        <= anode_d;
            seg_q          <= seg_d;
            dp_q           <= dp_d;
        end
    end

    // Board polarity applied at the pins.
    assign seg_o   = seg_q ^ {7{ACTIVE_LOW}};
    assign dp_o    = dp_q ^ ACTIVE_LOW;
    assign anode_o = anode_q ^ {NUM_DIGITS{ACTIVE_LOW}};

endmodule

// File: tb/tb_disp_out_mux.sv
// Testbench for disp_out_mux: a 4-digit active-low instance and a 1-digit
// active-high instance share clock, reset and enable.
module tb_disp_out_mux;

    localparam int N  = 4;
    localparam int RD = 4;
    localparam int G  = 1;
    localparam int F  = N * RD;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        en;
    logic [15:0] data;
    logic [3:0]  dp, blank;
    logic [6:0]  seg;
    logic        dpo;
    logic [3:0]  an;

    logic [3:0]  data1;
    logic        blank1;
    logic [6:0]  seg1;
    logic        dpo1;
    logic        an1;

    int n_cmp = 0;
    int n_err = 0;

    disp_out_mux #(.NUM_DIGITS(N), .REFRESH_DIV(RD), .GHOST_CYCLES(G), .ACTIVE_LOW(1'b1)) u_dut (
        .clk(clk), .rst_n(rst_n), .enable_i(en), .data_i(data), .dp_i(dp), .blank_i(blank),
        .seg_o(seg), .dp_o(dpo), .anode_o(an)
    );

    disp_out_mux #(.NUM_DIGITS(1), .REFRESH_DIV(RD), .GHOST_CYCLES(G), .ACTIVE_LOW(1'b0)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .enable_i(en), .data_i(data1), .dp_i(dp[0]), .blank_i(blank1),
        .seg_o(seg1), .dp_o(dpo1), .anode_o(an1)
    );

    always #5 clk = ~clk;

    logic [6:0] seg_tab [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                 7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

    // Reference model: cycle count since reset release plus frame snapshots.
    int          c;
    logic [15:0] m_data;
    logic [3:0]  m_dp, m_blank;
    logic [3:0]  m1_data;
    logic        m1_dp, m1_blank;

    typedef struct {
        logic       en;
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpo;
    } vec_t;

    vec_t basic [16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at c=%0d: got %h expected %h", nm, c, act, exp);
        end
    endtask

    task automatic model_reset();
        c = 0;
        m_data = '0; m_dp = '0; m_blank = '0;
        m1_data = '0; m1_dp = 1'b0; m1_blank = 1'b0;
    endtask

    // One clock: predict from pre-edge state and inputs, then compare.
    task automatic tick();
        int slot, pos;
        logic act, act1;
        logic [3:0] onehot, e_an;
        logic [6:0] e_seg, e_seg1;
        logic e_dp, e_dp1;
        slot   = (c / RD) % N;
        pos    = c % RD;
        act    = en && !m_blank[slot] && (pos >= G);
        onehot = 4'b0001 << slot;
        e_an   = act ? ~onehot : 4'hF;
        e_seg  = act ? ~seg_tab[m_data[4*slot +: 4]] : 7'h7F;
        e_dp   = !(act && m_dp[slot]);
        act1   = en && !m1_blank && (pos >= G);
        e_seg1 = act1 ? seg_tab[m1_data] : 7'h00;
        e_dp1  = act1 && m1_dp;
        if (c == 0 || (c % F) == F - 1) begin
            m_data = data; m_dp = dp; m_blank = blank;
        end
        if (c == 0 || pos == RD - 1) begin
            m1_data = data1; m1_dp = dp[0]; m1_blank = blank1;
        end
        @(posedge clk);
        #1;
        chk("anode",  32'(an),   32'(e_an));
        chk("seg",    32'(seg),  32'(e_seg));
        chk("dp",     32'(dpo),  32'(e_dp));
        chk("anode1", 32'(an1),  32'(act1));
        chk("seg1",   32'(seg1), 32'(e_seg1));
        chk("dp1",    32'(dpo1), 32'(e_dp1));
        c++;
    endtask

    task automatic run_until(input int k);
        while (c <= k) tick();
    endtask

    int cnt, nb, nbad, ndp, k;

    initial begin
        basic = '{
            '{1'b1, 4'hF, 7'h7F, 1'b1}, '{1'b1, 4'hE, 7'h40, 1'b1}, '{1'b1, 4'hE, 7'h40, 1'b1}, '{1'b1, 4'hE, 7'h40, 1'b1},
            '{1'b1, 4'hF, 7'h7F, 1'b1}, '{1'b1, 4'hD, 7'h79, 1'b1}, '{1'b1, 4'hD, 7'h79, 1'b1}, '{1'b1, 4'hD, 7'h79, 1'b1},
            '{1'b1, 4'hF, 7'h7F, 1'b1}, '{1'b1, 4'hB, 7'h24, 1'b1}, '{1'b1, 4'hB, 7'h24, 1'b1}, '{1'b1, 4'hB, 7'h24, 1'b1},
            '{1'b1, 4'hF, 7'h7F, 1'b1}, '{1'b1, 4'h7, 7'h30, 1'b1}, '{1'b1, 4'h7, 7'h30, 1'b1}, '{1'b1, 4'h7, 7'h30, 1'b1}
        };
        en = 1'b1; data = 16'h3210; dp = 4'b0000; blank = 4'b0000;
        data1 = 4'h8; blank1 = 1'b0;
        model_reset();

        // Reset values before and during clocks.
        #1;
        chk("rst_seg_t0",   32'(seg), 32'h7F);
        chk("rst_dp_t0",    32'(dpo), 32'h1);
        chk("rst_anode_t0", 32'(an),  32'hF);
        chk("rst_anode1_t0", 32'(an1), 32'h0);
        repeat (2) @(posedge clk);
        #1;
        chk("rst_anode_held", 32'(an),  32'hF);
        chk("rst_seg_held",   32'(seg), 32'h7F);
        rst_n = 1'b1;

        // Basic scan table.
        cnt = 0;
        for (int i = 0; i < 16; i++) begin
            en = basic[i].en;
            tick();
            chk("tab_anode", 32'(an),  32'(basic[i].an));
            chk("tab_seg",   32'(seg), 32'(basic[i].seg));
            chk("tab_dp",    32'(dpo), 32'(basic[i].dpo));
            if (an1) cnt++;
        end
        chk("pol1_active_cycles", 32'(cnt), 32'(RD - G) * 32'(N));

        // Snapshot isolation: change data while digit 1 is shown.
        run_until(21);
        data = 16'hFFFF;
        run_until(25);
        chk("iso_d2_anode", 32'(an),  32'hB);
        chk("iso_d2_seg",   32'(seg), 32'h24);
        run_until(29);
        chk("iso_d3_anode", 32'(an),  32'h7);
        chk("iso_d3_seg",   32'(seg), 32'h30);
        run_until(33);
        chk("iso_new_anode", 32'(an),  32'hE);
        chk("iso_new_seg",   32'(seg), 32'h0E);

        // Blank digit 2 and dp on digit 0 over one full frame.
        blank = 4'b0100; dp = 4'b0001;
        run_until(c + (F - 1 - (c % F)));
        nb = 0; nbad = 0; ndp = 0;
        for (int i = 0; i < F; i++) begin
            tick();
            if (an == 4'hB) nb++;
            if (!dpo && an != 4'hE) nbad++;
            if (!dpo) ndp++;
        end
        chk("blank_never_B",  32'(nb),   32'h0);
        chk("dp_only_digit0", 32'(nbad), 32'h0);
        chk("dp_lit_cycles",  32'(ndp),  32'(RD - G));

        // One-cycle enable drop mid-slot.
        while ((c % F) != 2) tick();
        en = 1'b0;
        tick();
        chk("en_off_anode", 32'(an),  32'hF);
        chk("en_off_seg",   32'(seg), 32'h7F);
        en = 1'b1;
        tick();
        chk("en_back_anode", 32'(an), 32'hE);
        tick();
        chk("en_slot_end", 32'(an), 32'hF);

        // Reset during digit 2.
        blank = 4'b0000;
        run_until(c + (F - 1 - (c % F)));
        run_until(c + 9);
        chk("pre_rst_anode", 32'(an), 32'hB);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_anode",  32'(an),   32'hF);
        chk("mid_rst_seg",    32'(seg),  32'h7F);
        chk("mid_rst_dp",     32'(dpo),  32'h1);
        chk("mid_rst_anode1", 32'(an1),  32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        model_reset();
        k = 0;
        while (an == 4'hF && k < 20) begin
            tick();
            k++;
        end
        chk("post_rst_latency", 32'(k),  32'(1 + G));
        chk("post_rst_anode",   32'(an), 32'hE);

        // Randomized traffic against the model.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 3) == 0) data = 16'($urandom);
            if ($urandom_range(0, 5) == 0) dp = 4'($urandom);
            if ($urandom_range(0, 7) == 0) blank = 4'($urandom) & 4'($urandom);
            if ($urandom_range(0, 3) == 0) data1 = 4'($urandom);
            if ($urandom_range(0, 9) == 0) blank1 = ~blank1;
            en = ($urandom_range(0, 9) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
